// File: rtl/mem_access_unit.sv
// Load/store unit between a pipeline and a word-wide DataMemory.
// Define MEM_ACCESS_BIG_ENDIAN_EN for big-endian lane mapping; the default is little-endian.
module mem_access_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        Req,
  input  logic        Write,
  input  logic [1:0]  Size,
  input  logic        Unsigned,
  input  logic [31:0] Addr,
  input  logic [31:0] StoreData,
  output logic        Busy,
  output logic        Done,
  output logic [31:0] LoadData,
  output logic        AddrErr,
  output logic        ReadMem,
  output logic        WriteMem,
  output logic [31:0] MemAddr,
  output logic [31:0] MemWData,
  input  logic [31:0] MemRData
);

  typedef enum logic [2:0] {
    StIdle,
    StRd,
    StCap,
    StMerge,
    StWr
  } state_e;

  state_e      state_q, state_d;
  logic        write_q;
  logic        unsigned_q;
  logic [1:0]  size_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [31:0] load_q;
  logic        done_q;
  logic        err_q;

  logic        misaligned;
  logic [4:0]  byte_off;
  logic [4:0]  half_off;
  logic [4:0]  lane_off;
  logic [31:0] lane_mask;
  logic [31:0] rshift;
  logic [31:0] extracted;
  logic [31:0] merged;

  always_comb begin
    unique case (Size)
      2'b00:   misaligned = 1'b0;
      2'b01:   misaligned = Addr[0];
      2'b10:   misaligned = |Addr[1:0];
      default: misaligned = 1'b1;
    endcase
  end

  // Bit offset of the addressed lane inside the memory word.
`ifdef MEM_ACCESS_BIG_ENDIAN_EN
  assign byte_off = {~addr_q[1:0], 3'b000};
  assign half_off = {~addr_q[1], 4'b0000};
`else
  assign byte_off = {addr_q[1:0], 3'b000};
  assign half_off = {addr_q[1], 4'b0000};
`endif

  assign lane_off  = size_q[0] ? half_off : byte_off;
  assign lane_mask = (size_q[0] ? 32'h0000_ffff : 32'h0000_00ff) << lane_off;
  assign rshift    = MemRData >> lane_off;
  assign merged    = (MemRData & ~lane_mask) | ((wdata_q << lane_off) & lane_mask);

  always_comb begin
    extracted = MemRData;
    unique case (size_q)
      2'b00:   extracted = {{24{~unsigned_q & rshift[7]}}, rshift[7:0]};
      2'b01:   extracted = {{16{~unsigned_q & rshift[15]}}, rshift[15:0]};
      default: extracted = MemRData;
    endcase
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (Req && !misaligned) begin
          state_d = (Write && (Size == 2'b10)) ? StWr : StRd;
        end
      end
      StRd:    state_d = write_q ? StMerge : StCap;
      StCap:   state_d = StIdle;
      StMerge: state_d = StWr;
      StWr:    state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      write_q    <= 1'b0;
      unsigned_q <= 1'b0;
      size_q     <= 2'b00;
      addr_q     <= 32'h0;
      wdata_q    <= 32'h0;
      load_q     <= 32'h0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      if ((state_q == StIdle) && Req) begin
        write_q    <= Write;
        size_q     <= Size;
        unsigned_q <= Unsigned;
        addr_q     <= Addr;
        wdata_q    <= StoreData;
        // Rejected requests complete immediately without touching memory.
        if (misaligned) begin
          done_q <= 1'b1;
          err_q  <= 1'b1;
        end
      end
      if (state_q == StCap) begin
        load_q <= extracted;
        done_q <= 1'b1;
      end
      if (state_q == StMerge) begin
        wdata_q <= merged;
      end
      if (state_q == StWr) begin
        done_q <= 1'b1;
      end
    end
  end

  assign Busy     = (state_q != StIdle);
  assign ReadMem  = (state_q == StRd);
  assign WriteMem = (state_q == StWr);
  assign MemAddr  = {addr_q[31:2], 2'b00};
  assign MemWData = wdata_q;
  assign Done     = done_q;
  assign AddrErr  = err_q;
  assign LoadData = load_q;

endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset; ports named as below.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  synchronous active-high reset.
REQ-004 Req  input  1  pipeline request strobe; sampled only in IDLE.
REQ-005 Write  input  1  1 = store, 0 = load.
REQ-006 Size  input  2  00 byte, 01 halfword, 10 word, 11 illegal.
REQ-007 Unsigned  input  1  load extension: 1 = zero-extend, 0 = sign-extend.
REQ-008 Addr  input  32  byte address.
REQ-009 StoreData  input  32  store value, right-justified.
REQ-010 Busy  output  1  high from the cycle after accept until the cycle before Done.
REQ-011 Done  output  1  one-cycle completion pulse.
REQ-012 LoadData  output  32  extended load result, valid while Done is high.
REQ-013 AddrErr  output  1  high with Done when the request was rejected.
REQ-014 ReadMem  output  1  DataMemory read enable.
REQ-015 WriteMem  output  1  DataMemory write enable; the write commits on the clk edge that ends the cycle.
REQ-016 MemAddr  output  32  word-aligned address: {Addr[31:2],2'b00}.
REQ-017 MemWData  output  32  full word to DataMemory.
REQ-018 MemRData  input  32  DataMemory read data, valid the cycle after ReadMem is asserted.

Function
REQ-019 States SHALL be IDLE, RD, CAP, MERGE, WR.
REQ-020 In IDLE, Req=1 SHALL latch Write, Size, Unsigned, Addr and StoreData; Req is ignored in every other state.
REQ-021 Misalignment SHALL be Size=01 with Addr[0]=1, Size=10 with Addr[1:0]!=0, or Size=11.
REQ-022 A misaligned request SHALL stay in IDLE, issue no ReadMem/WriteMem, and pulse Done=1 with AddrErr=1 in the next cycle.
REQ-023 Load path: IDLE->RD (ReadMem=1)->CAP (register the extracted MemRData)->IDLE; Done SHALL pulse 3 cycles after accept.
REQ-024 Word store path: IDLE->WR (WriteMem=1, MemWData=StoreData)->IDLE; Done SHALL pulse 2 cycles after accept.
REQ-025 Sub-word store path: IDLE->RD->MERGE (replace the addressed lane of MemRData with StoreData[7:0] or [15:0] and register the word)->WR->IDLE; Done SHALL pulse 4 cycles after accept.
REQ-026 Byte lane k=Addr[1:0] SHALL map to bits [8k+7:8k]; halfword lane h=Addr[1] SHALL map to bits [16h+15:16h].
REQ-027 A load SHALL extend the selected byte or half to 32 bits per Unsigned; word loads SHALL pass through unchanged.
REQ-028 ReadMem and WriteMem SHALL never both be high, and each SHALL be high for at most one cycle per request.
REQ-029 A new Req SHALL be accepted in the same cycle that Done is high (back-to-back operation).
REQ-030 LoadData SHALL hold its value until the next load completes; AddrErr SHALL be low whenever Done is low.

Reset
REQ-031 While rst=1 the state SHALL go to IDLE and all outputs and latched registers SHALL be 0 at the next edge.
REQ-032 A reset asserted in RD, MERGE or WR SHALL abort the operation: no WriteMem in the cycle after reset, and no Done.

Configuration
REQ-033 Macro MEM_ACCESS_BIG_ENDIAN_EN undefined: lane mapping SHALL be as in REQ-026 (little-endian).
REQ-034 Macro MEM_ACCESS_BIG_ENDIAN_EN defined: byte lane k SHALL map to bits [31-8k:24-8k] and halfword h to bits [31-16h:16-16h], for both loads and stores; timing SHALL be unchanged.

Verification
REQ-035 Word store Addr=0x10, StoreData=0xDEADBEEF, then word load of 0x10 -> WriteMem one cycle with MemAddr=0x10; load Done at +3 with LoadData=0xDEADBEEF.
REQ-036 Memory word 0x10=0x11223344; byte store Addr=0x11, StoreData=0xAA -> MemWData=0x1122AA44; Done at +4.
REQ-037 Byte load Addr=0x13 from word 0x80112233, Unsigned=0 -> LoadData=0xFFFFFF80; with Unsigned=1 -> 0x00000080.
REQ-038 Half load Addr=0x0D or word load Addr=0x0E -> Done+AddrErr next cycle; no ReadMem or WriteMem.
REQ-039 Assert rst during MERGE of a byte store -> no WriteMem and no Done; Busy=0 and the target word is unchanged.
REQ-040 With MEM_ACCESS_BIG_ENDIAN_EN defined, byte store Addr=0x10, 0xAA onto 0x11223344 -> MemWData=0xAA223344.
